// File: rtl/bosconian_pkg.sv
// Shared definitions for the Bosconian ROM loader: download region map,
// region codes and loader FSM states.
package bosconian_pkg;

  typedef enum logic [3:0] {
    RGN_MAIN    = 4'd0,
    RGN_SUB     = 4'd1,
    RGN_SOUND   = 4'd2,
    RGN_CHARS   = 4'd3,
    RGN_SPRITES = 4'd4,
    RGN_DOTS    = 4'd5,
    RGN_PALETTE = 4'd6,
    RGN_LOOKUP  = 4'd7,
    RGN_WAVE    = 4'd8
  } region_e;

  localparam logic [16:0] MAIN_BASE    = 17'h00000;
  localparam logic [16:0] MAIN_SIZE    = 17'h04000;
  localparam logic [16:0] SUB_BASE     = 17'h04000;
  localparam logic [16:0] SUB_SIZE     = 17'h02000;
  localparam logic [16:0] SOUND_BASE   = 17'h06000;
  localparam logic [16:0] SOUND_SIZE   = 17'h01000;
  localparam logic [16:0] CHARS_BASE   = 17'h07000;
  localparam logic [16:0] CHARS_SIZE   = 17'h01000;
  localparam logic [16:0] SPRITES_BASE = 17'h08000;
  localparam logic [16:0] SPRITES_SIZE = 17'h01000;
  localparam logic [16:0] DOTS_BASE    = 17'h09000;
  localparam logic [16:0] DOTS_SIZE    = 17'h00100;
  localparam logic [16:0] PALETTE_BASE = 17'h09100;
  localparam logic [16:0] PALETTE_SIZE = 17'h00020;
  localparam logic [16:0] LOOKUP_BASE  = 17'h09120;
  localparam logic [16:0] LOOKUP_SIZE  = 17'h00100;
  localparam logic [16:0] WAVE_BASE    = 17'h09220;
  localparam logic [16:0] WAVE_SIZE    = 17'h00100;

  // First byte address past the last mapped region.
  localparam logic [16:0] MAP_END = WAVE_BASE + WAVE_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/bosconian_rom_loader_if.sv
// Bundle of the HPS ioctl download bus and the routed ROM write port.
interface bosconian_rom_loader_if;

  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        dn_wr;
  logic [3:0]  dn_region;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data;
  logic        core_reset;
  logic        load_ok;
  logic        load_err;
  logic [16:0] byte_count;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_wr, dn_region, dn_addr, dn_data, core_reset, load_ok, load_err, byte_count
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_wr, dn_region, dn_addr, dn_data, core_reset, load_ok, load_err, byte_count
  );

endinterface

// File: rtl/bosconian_rom_decode.sv
// Combinational map from a download byte address to ROM region, offset
// within that region, and whether the byte belongs to the ROM set at all.
module bosconian_rom_decode
  import bosconian_pkg::*;
#(
  parameter logic [16:0] TOTAL_BYTES = 17'h09320
) (
  input  logic [24:0] addr,
  output logic [3:0]  region,
  output logic [13:0] offset,
  output logic        in_range
);

  logic [16:0] low_addr;
  logic [13:0] base_lo;

  assign low_addr = addr[16:0];

  // Regions are contiguous and ascending, so the first end boundary above
  // the address selects the region.
  always_comb begin
    region  = RGN_MAIN;
    base_lo = MAIN_BASE[13:0];
    if (low_addr < MAIN_BASE + MAIN_SIZE) begin
      region  = RGN_MAIN;
      base_lo = MAIN_BASE[13:0];
    end else if (low_addr < SUB_BASE + SUB_SIZE) begin
      region  = RGN_SUB;
      base_lo = SUB_BASE[13:0];
    end else if (low_addr < SOUND_BASE + SOUND_SIZE) begin
      region  = RGN_SOUND;
      base_lo = SOUND_BASE[13:0];
    end else if (low_addr < CHARS_BASE + CHARS_SIZE) begin
      region  = RGN_CHARS;
      base_lo = CHARS_BASE[13:0];
    end else if (low_addr < SPRITES_BASE + SPRITES_SIZE) begin
      region  = RGN_SPRITES;
      base_lo = SPRITES_BASE[13:0];
    end else if (low_addr < DOTS_BASE + DOTS_SIZE) begin
      region  = RGN_DOTS;
      base_lo = DOTS_BASE[13:0];
    end else if (low_addr < PALETTE_BASE + PALETTE_SIZE) begin
      region  = RGN_PALETTE;
      base_lo = PALETTE_BASE[13:0];
    end else if (low_addr < LOOKUP_BASE + LOOKUP_SIZE) begin
      region  = RGN_LOOKUP;
      base_lo = LOOKUP_BASE[13:0];
    end else if (low_addr < WAVE_BASE + WAVE_SIZE) begin
      region  = RGN_WAVE;
      base_lo = WAVE_BASE[13:0];
    end
  end

  // No region exceeds 16K, so the low 14 bits of the difference are exact.
  assign offset   = low_addr[13:0] - base_lo;
  assign in_range = (addr[24:17] == 8'd0) && (low_addr < MAP_END) &&
                    (low_addr < TOTAL_BYTES);

endmodule

// File: rtl/bosconian_rom_loader.sv
// Accepts the Bosconian ROM set from the ioctl download bus, routes each byte
// to its ROM region and validates the download size before releasing the core.
module bosconian_rom_loader
  import bosconian_pkg::*;
#(
  parameter logic [16:0] TOTAL_BYTES = 17'h09320,
  parameter logic [7:0]  ROM_INDEX   = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        dn_wr,
  output logic [3:0]  dn_region,
  output logic [13:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err,
  output logic [16:0] byte_count
);

  state_e      state_q;
  logic        dl_prev_q;
  logic [16:0] byte_count_q;
  logic [16:0] byte_count_d;
  logic        overflow_q;
  logic        load_ok_q;
  logic        load_err_q;
  logic        core_reset_q;
  logic        dn_wr_q;
  logic [3:0]  dn_region_q;
  logic [13:0] dn_addr_q;
  logic [7:0]  dn_data_q;

  logic        dl_active;
  logic        dl_rise;
  logic        accept;
  logic [3:0]  dec_region;
  logic [13:0] dec_offset;
  logic        dec_in_range;

  bosconian_rom_decode #(
    .TOTAL_BYTES (TOTAL_BYTES)
  ) u_decode (
    .addr     (ioctl_addr),
    .region   (dec_region),
    .offset   (dec_offset),
    .in_range (dec_in_range)
  );

  assign dl_active = ioctl_download && (ioctl_index == ROM_INDEX);
  assign dl_rise   = dl_active && !dl_prev_q;
  // Download is not checked here so the byte strobed as the download falls
  // (the only LOAD cycle with download low) is still taken.
  assign accept    = (state_q == LOAD) && ioctl_wr && (ioctl_index == ROM_INDEX);

  assign byte_count_d = (byte_count_q == 17'h1FFFF) ? byte_count_q
                                                    : byte_count_q + 17'd1;

  // dl_prev_q resets high so a transfer already running at reset release
  // has to drop and restart before it is accepted.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      dl_prev_q    <= 1'b1;
      byte_count_q <= '0;
      overflow_q   <= 1'b0;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
      core_reset_q <= 1'b1;
      dn_wr_q      <= 1'b0;
      dn_region_q  <= '0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
    end else begin
      dl_prev_q <= dl_active;
      dn_wr_q   <= 1'b0;

      if (accept) begin
        byte_count_q <= byte_count_d;
        if (dec_in_range) begin
          dn_wr_q     <= 1'b1;
          dn_region_q <= dec_region;
          dn_addr_q   <= dec_offset;
          dn_data_q   <= ioctl_dout;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE, DONE, ERROR: begin
          if (dl_rise) begin
            state_q      <= LOAD;
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
            load_ok_q    <= 1'b0;
            load_err_q   <= 1'b0;
            core_reset_q <= 1'b1;
          end
        end
        LOAD: begin
          if (!ioctl_download) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if ((byte_count_q == TOTAL_BYTES) && !overflow_q) begin
            state_q      <= DONE;
            load_ok_q    <= 1'b1;
            core_reset_q <= 1'b0;
          end else begin
            state_q    <= ERROR;
            load_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dn_wr      = dn_wr_q;
  assign dn_region  = dn_region_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign core_reset = core_reset_q;
  assign load_ok    = load_ok_q;
  assign load_err   = load_err_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_bosconian_rom_loader.sv
// Self-checking bench for bosconian_rom_loader: region-boundary vector table,
// full/short/long/foreign-index downloads and reset mid-download.
module tb_bosconian_rom_loader;
  import bosconian_pkg::*;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        expWrite;
    logic [3:0]  expRegion;
    logic [13:0] expOffset;
  } vec_t;

  typedef struct {
    logic [3:0]  region;
    logic [13:0] offset;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  bosconian_rom_loader_if bus ();

  int   checks      = 0;
  int   failures    = 0;
  int   cyc         = 0;
  int   pulseCount  = 0;
  int   pulseMark   = 0;
  exp_t sb[$];
  exp_t mon;
  vec_t vecs[22];

  int unsigned regionBase[9] = '{32'h00000, 32'h04000, 32'h06000, 32'h07000,
                                 32'h08000, 32'h09000, 32'h09100, 32'h09120,
                                 32'h09220};

  bosconian_rom_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (bus.ioctl_download),
    .ioctl_index    (bus.ioctl_index),
    .ioctl_wr       (bus.ioctl_wr),
    .ioctl_addr     (bus.ioctl_addr),
    .ioctl_dout     (bus.ioctl_dout),
    .dn_wr          (bus.dn_wr),
    .dn_region      (bus.dn_region),
    .dn_addr        (bus.dn_addr),
    .dn_data        (bus.dn_data),
    .core_reset     (bus.core_reset),
    .load_ok        (bus.load_ok),
    .load_err       (bus.load_err),
    .byte_count     (bus.byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] modelRegion(input int unsigned a);
    for (int i = 8; i >= 0; i--) begin
      if (a >= regionBase[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // One byte strobe; a routed write is expected one cycle after sampling.
  task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data,
                               input logic expWrite, input logic [3:0] region,
                               input logic [13:0] offset);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    if (expWrite) sb.push_back('{region: region, offset: offset, data: data, cyc: cyc + 1});
    @(posedge clk_sys);
    #1;
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic applyModelByte(input int unsigned a, input logic expWrite);
    logic [3:0] r;
    r = modelRegion(a);
    applyStimulus(25'(a), 8'(a * 7 + 3), expWrite, r, 14'(a - regionBase[r]));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic startDownload(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    idle(1);
  endtask

  task automatic finishDownload();
    bus.ioctl_download = 1'b0;
    idle(4);
  endtask

  always @(negedge clk_sys) begin
    checks++;
    if (bus.load_ok === 1'b1 && bus.load_err === 1'b1) begin
      failures++;
      $display("[TB] FAIL ok_err_exclusive actual=both_high required=not_both");
    end
    if (bus.dn_wr === 1'b1) begin
      pulseCount++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_dn_wr actual=1 required=0 region=%0d addr=0x%0h",
                 bus.dn_region, bus.dn_addr);
      end else begin
        mon = sb.pop_front();
        checkOutput("dn_region", 32'(bus.dn_region), 32'(mon.region));
        checkOutput("dn_addr", 32'(bus.dn_addr), 32'(mon.offset));
        checkOutput("dn_data", 32'(bus.dn_data), 32'(mon.data));
        checkOutput("dn_latency", cyc, mon.cyc);
      end
    end
  end

  initial begin
    vecs[0]  = '{25'h0000000, 8'h11, 1'b1, 4'd0, 14'h0000};
    vecs[1]  = '{25'h0003FFF, 8'h22, 1'b1, 4'd0, 14'h3FFF};
    vecs[2]  = '{25'h0004000, 8'h33, 1'b1, 4'd1, 14'h0000};
    vecs[3]  = '{25'h0004005, 8'h44, 1'b1, 4'd1, 14'h0005};
    vecs[4]  = '{25'h0005FFF, 8'h55, 1'b1, 4'd1, 14'h1FFF};
    vecs[5]  = '{25'h0006000, 8'h66, 1'b1, 4'd2, 14'h0000};
    vecs[6]  = '{25'h0006FFF, 8'h77, 1'b1, 4'd2, 14'h0FFF};
    vecs[7]  = '{25'h0007000, 8'h88, 1'b1, 4'd3, 14'h0000};
    vecs[8]  = '{25'h0007FFF, 8'h99, 1'b1, 4'd3, 14'h0FFF};
    vecs[9]  = '{25'h0008000, 8'hAA, 1'b1, 4'd4, 14'h0000};
    vecs[10] = '{25'h0008FFF, 8'hBB, 1'b1, 4'd4, 14'h0FFF};
    vecs[11] = '{25'h0009000, 8'hCC, 1'b1, 4'd5, 14'h0000};
    vecs[12] = '{25'h00090FF, 8'hDD, 1'b1, 4'd5, 14'h00FF};
    vecs[13] = '{25'h0009100, 8'hEE, 1'b1, 4'd6, 14'h0000};
    vecs[14] = '{25'h000911F, 8'h01, 1'b1, 4'd6, 14'h001F};
    vecs[15] = '{25'h0009120, 8'h02, 1'b1, 4'd7, 14'h0000};
    vecs[16] = '{25'h000921F, 8'h03, 1'b1, 4'd7, 14'h00FF};
    vecs[17] = '{25'h0009220, 8'h04, 1'b1, 4'd8, 14'h0000};
    vecs[18] = '{25'h000931F, 8'h5A, 1'b1, 4'd8, 14'h00FF};
    vecs[19] = '{25'h0009320, 8'h06, 1'b0, 4'd0, 14'h0000};
    vecs[20] = '{25'h0020000, 8'h07, 1'b0, 4'd0, 14'h0000};
    vecs[21] = '{25'h1009000, 8'h08, 1'b0, 4'd0, 14'h0000};

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;

    reset = 1'b1;
    idle(3);
    checkOutput("rst_dn_wr", 32'(bus.dn_wr), 32'd0);
    checkOutput("rst_dn_region", 32'(bus.dn_region), 32'd0);
    checkOutput("rst_dn_addr", 32'(bus.dn_addr), 32'd0);
    checkOutput("rst_dn_data", 32'(bus.dn_data), 32'd0);
    checkOutput("rst_byte_count", 32'(bus.byte_count), 32'd0);
    checkOutput("rst_load_ok", 32'(bus.load_ok), 32'd0);
    checkOutput("rst_load_err", 32'(bus.load_err), 32'd0);
    checkOutput("rst_core_reset", 32'(bus.core_reset), 32'd1);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    idle(2);

    $display("[TB] foreign index download from IDLE");
    pulseMark = pulseCount;
    startDownload(8'd254);
    for (int i = 0; i < 16; i++) applyStimulus(25'(i), 8'(i), 1'b0, 4'd0, 14'd0);
    finishDownload();
    checkOutput("idx254_idle_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("idx254_idle_count", 32'(bus.byte_count), 32'd0);
    checkOutput("idx254_idle_pulses", pulseCount - pulseMark, 32'd0);

    $display("[TB] region boundary vectors");
    pulseMark = pulseCount;
    startDownload(8'd0);
    for (int i = 0; i < 22; i++)
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].expWrite,
                    vecs[i].expRegion, vecs[i].expOffset);
    finishDownload();
    checkOutput("vec_pulses", pulseCount - pulseMark, 32'd19);
    checkOutput("vec_byte_count", 32'(bus.byte_count), 32'd22);
    checkOutput("vec_load_err", 32'(bus.load_err), 32'd1);
    checkOutput("vec_load_ok", 32'(bus.load_ok), 32'd0);
    checkOutput("vec_state", 32'(dut.state_q), 32'(ERROR));
    checkOutput("hold_dn_region", 32'(bus.dn_region), 32'(vecs[18].expRegion));
    checkOutput("hold_dn_addr", 32'(bus.dn_addr), 32'(vecs[18].expOffset));
    checkOutput("hold_dn_data", 32'(bus.dn_data), 32'(vecs[18].data));

    $display("[TB] short download");
    pulseMark = pulseCount;
    startDownload(8'd0);
    for (int unsigned a = 0; a < 32'h200; a++) applyModelByte(a, 1'b1);
    finishDownload();
    checkOutput("short_pulses", pulseCount - pulseMark, 32'h200);
    checkOutput("short_byte_count", 32'(bus.byte_count), 32'h200);
    checkOutput("short_load_err", 32'(bus.load_err), 32'd1);
    checkOutput("short_load_ok", 32'(bus.load_ok), 32'd0);
    checkOutput("short_core_reset", 32'(bus.core_reset), 32'd1);

    $display("[TB] reset in the middle of a download");
    startDownload(8'd0);
    for (int unsigned a = 0; a < 32'h100; a++) applyModelByte(a, 1'b1);
    reset = 1'b1;
    applyModelByte(32'h100, 1'b0);
    pulseMark = pulseCount;
    for (int unsigned a = 32'h101; a < 32'h104; a++) applyModelByte(a, 1'b0);
    reset = 1'b0;
    for (int unsigned a = 32'h104; a < 32'h124; a++) applyModelByte(a, 1'b0);
    checkOutput("midrst_pulses", pulseCount - pulseMark, 32'd0);
    checkOutput("midrst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("midrst_core_reset", 32'(bus.core_reset), 32'd1);
    checkOutput("midrst_byte_count", 32'(bus.byte_count), 32'd0);
    finishDownload();
    checkOutput("midrst_state_after", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] full download, last byte as download falls");
    pulseMark = pulseCount;
    startDownload(8'd0);
    for (int unsigned a = 0; a < 32'h931F; a++) applyModelByte(a, 1'b1);
    bus.ioctl_download = 1'b0;
    applyModelByte(32'h931F, 1'b1);
    idle(3);
    checkOutput("full_pulses", pulseCount - pulseMark, 32'h9320);
    checkOutput("full_byte_count", 32'(bus.byte_count), 32'h9320);
    checkOutput("full_load_ok", 32'(bus.load_ok), 32'd1);
    checkOutput("full_load_err", 32'(bus.load_err), 32'd0);
    checkOutput("full_core_reset", 32'(bus.core_reset), 32'd0);
    checkOutput("full_state", 32'(dut.state_q), 32'(DONE));
    checkOutput("full_last_addr", 32'(bus.dn_addr), 32'h00FF);

    $display("[TB] foreign index download from DONE");
    pulseMark = pulseCount;
    startDownload(8'd254);
    for (int i = 0; i < 16; i++) applyStimulus(25'(i), 8'(i), 1'b0, 4'd0, 14'd0);
    finishDownload();
    checkOutput("idx254_done_state", 32'(dut.state_q), 32'(DONE));
    checkOutput("idx254_done_count", 32'(bus.byte_count), 32'h9320);
    checkOutput("idx254_done_pulses", pulseCount - pulseMark, 32'd0);
    checkOutput("idx254_done_core_reset", 32'(bus.core_reset), 32'd0);

    $display("[TB] download one byte too long");
    pulseMark = pulseCount;
    startDownload(8'd0);
    checkOutput("long_start_load_ok", 32'(bus.load_ok), 32'd0);
    checkOutput("long_start_core_reset", 32'(bus.core_reset), 32'd1);
    for (int unsigned a = 0; a < 32'h9321; a++) applyModelByte(a, a < 32'h9320);
    finishDownload();
    checkOutput("long_pulses", pulseCount - pulseMark, 32'h9320);
    checkOutput("long_byte_count", 32'(bus.byte_count), 32'h9321);
    checkOutput("long_load_err", 32'(bus.load_err), 32'd1);
    checkOutput("long_load_ok", 32'(bus.load_ok), 32'd0);
    checkOutput("long_core_reset", 32'(bus.core_reset), 32'd1);
    checkOutput("long_state", 32'(dut.state_q), 32'(ERROR));

    idle(2);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
